// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - boots the PC, fetches from instruction memory and hands words to decode
module fetch_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter int                INSTR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [ADDR_W-1:0]  PC,
    output logic [ADDR_W-1:0]  PC_IN,
    output logic               W_PC,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic               IMEM_READY,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    input  logic               STALL,
    input  logic               BR_TAKEN,
    input  logic [ADDR_W-1:0]  BR_TARGET,
    output logic [INSTR_W-1:0] INSTR,
    output logic [ADDR_W-1:0]  INSTR_PC,
    output logic               INSTR_VALID
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    // Low only between reset release and the first edge, so W_PC stays 0 in reset.
    logic               started;
    logic               pending;
    logic [ADDR_W-1:0]  pend_target;
    logic [ADDR_W-1:0]  pc_inc;
    logic               fire;
    logic               squash;
    logic               br_latch;

    always_comb begin
        state_next = state;
        IMEM_REQ   = 1'b0;
        case (state)
            S_BOOT: begin
                if (started) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (!STALL) begin
                    IMEM_REQ   = 1'b1;
                    state_next = IMEM_READY ? S_UPDATE : S_WAIT;
                end
            end
            S_WAIT: begin
                IMEM_REQ = 1'b1;
                if (IMEM_READY) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    assign IMEM_ADDR = IMEM_REQ ? PC : '0;
    assign fire      = IMEM_REQ & IMEM_READY;
    assign squash    = pending | BR_TAKEN;
    assign br_latch  = BR_TAKEN & ((state == S_FETCH) | (state == S_WAIT));
    assign W_PC      = ((state == S_BOOT) & started) | (state == S_UPDATE);

    always_comb begin
        PC_IN = RESET_VECTOR;
        if (state == S_UPDATE) begin
            if (pending)       PC_IN = pend_target;
            else if (BR_TAKEN) PC_IN = BR_TARGET;
            else               PC_IN = pc_inc;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_BOOT;
            started     <= 1'b0;
            pending     <= 1'b0;
            pend_target <= '0;
            pc_inc      <= '0;
            INSTR       <= '0;
            INSTR_PC    <= '0;
            INSTR_VALID <= 1'b0;
        end else begin
            state       <= state_next;
            started     <= 1'b1;
            INSTR_VALID <= fire & ~squash;
            if (state == S_UPDATE) begin
                pending <= 1'b0;
            end else if (br_latch) begin
                pending     <= 1'b1;
                pend_target <= BR_TARGET;
            end
            // PC is stable until UPDATE, so the increment is taken at capture.
            if (fire) pc_inc <= PC + ADDR_W'(1);
            if (fire && !squash) begin
                INSTR    <= IMEM_RDATA;
                INSTR_PC <= PC;
            end
        end
    end

endmodule
